inst_mem_responder: RTL and testbench
=====================================

// Module: inst_mem_responder
// PURPOSE
//   Responder end of the instruction-fetch interface: accepts a fetch request (byte PC) from
//   the fetch stage, reads one 16-bit instruction word from on-chip instruction memory, and
//   returns it with the PC echoed back, using a valid/ready handshake and configurable wait states.
//   Also owns a program-load write port driven by the testbench/boot loader.
// PARAMETERS
//   ADDR_W       16    byte-address width of req_addr/rsp_addr/ld_addr
//   DATA_W       16    instruction word width
//   DEPTH_WORDS  1024  memory depth in words (power of 2)
//   WAIT_CYCLES  1     extra cycles between accept and rsp_valid (0..15)
// PORTS
//   clk        in   1       clock; all state changes on posedge
//   rst        in   1       synchronous, active-high reset
//   req_valid  in   1       fetch request present
//   req_ready  out  1       responder can accept a request this cycle
//   req_addr   in   ADDR_W  byte PC; word index = req_addr[ADDR_W-1:1]
//   rsp_valid  out  1       rsp_data/rsp_addr/rsp_err valid
//   rsp_ready  in   1       fetch stage consumes the response
//   rsp_data   out  DATA_W  instruction word (ir)
//   rsp_addr   out  ADDR_W  PC of the returned word (currpc)
//   rsp_err    out  1       misaligned-fetch flag (tied 0 unless MISALIGN_TRAP_EN)
//   ld_en      in   1       program-load write strobe
//   ld_addr    in   ADDR_W  byte address of word to load
//   ld_data    in   DATA_W  word to load
// BEHAVIOUR
//   - Reset: state=IDLE, wait counter=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0; memory
//     contents NOT reset. Reset mid-request drops the in-flight request; no response is issued.
//   - FSM IDLE -> WAIT (accept, WAIT_CYCLES>0) | IDLE -> RESP (accept, WAIT_CYCLES=0);
//     WAIT counts down WAIT_CYCLES cycles -> RESP; RESP holds until rsp_ready, then IDLE, or
//     re-accepts: RESP -> WAIT/RESP if rsp_ready && req_valid in same cycle (back-to-back).
//   - req_ready = (state==IDLE) | (state==RESP & rsp_ready). Accept = req_valid & req_ready;
//     req_addr captured on accept; req_addr changes afterwards are ignored.
//   - Latency: rsp_valid asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
//     Back-to-back throughput with WAIT_CYCLES=0: one word per cycle.
//   - rsp_data/rsp_addr/rsp_err stable while rsp_valid & !rsp_ready; rsp_valid falls the cycle
//     after rsp_ready unless a new response completes that cycle.
//   - Array read happens on the edge entering RESP; index = captured addr[ADDR_W-1:1] mod
//     DEPTH_WORDS (upper bits wrap silently, no error).
//   - ld_en writes ld_data at ld_addr[ADDR_W-1:1] mod DEPTH_WORDS every cycle, independent of FSM.
//     Same-cycle write and read to the same word: read returns OLD data (read-before-write).
//   - rsp_addr = captured req_addr unmodified (bit 0 preserved).
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: req_addr[0]=1 -> same latency, rsp_err=1, rsp_data=16'h0000,
//     array not read. Undefined: bit 0 ignored, word at addr[ADDR_W-1:1] returned, rsp_err=0.
// STRUCTURE
//   - imem_pkg: FSM state enum (IDLE, WAIT, RESP), WAIT_CNT_W=4, NOP_WORD=16'h0000.
//   - Sub-module imem_array: single-port synchronous-read array, independent write port.
//   - Top: FSM, wait counter, request capture regs, response output regs.
// TESTING
//   1 Load 0x0000<-0x1234, 0x0002<-0xABCD; req 0x0002, WAIT=1 -> rsp_valid 2 cycles later,
//     rsp_data=0xABCD, rsp_addr=0x0002.
//   2 rsp_ready=0 for 3 cycles -> rsp_* held, req_ready=0; then rsp_ready=1 with req 0x0000
//     -> back-to-back accept, next rsp_data=0x1234.
//   3 WAIT=0, req_valid held, rsp_ready=1, addrs 0,2,4,6 -> one response per cycle, in order.
//   4 DEPTH_WORDS=1024, req 0x0802 -> returns word at 0x0002 (wrap).
//   5 Assert rst during WAIT -> next cycles rsp_valid=0, state IDLE, req_ready=1.
//   6 Req 0x0003: with MISALIGN_TRAP_EN rsp_err=1, rsp_data=0; without, rsp_data=0xABCD, rsp_err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int          WAIT_CNT_W = 4;
    localparam logic [15:0] NOP_WORD   = 16'h0000;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response channel between the fetch stage (master) and instruction memory (slave).
interface inst_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_array.sv
// Single-port synchronous-read word array with an independent write port.
// A read and write to the same word on one edge returns the old contents.
module imem_array #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value between reads so the response stays stable.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: valid/ready fetch with WAIT_CYCLES wait states and a program-load port.
// Optional MISALIGN_TRAP_EN: odd PCs return rsp_err=1 and a NOP word without reading the array.
module inst_mem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_responder_if.slave  bus,
    input  logic                 ld_en,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data
);
    localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam state_t                ACCEPT_ST = (WAIT_CYCLES == 0) ? RESP : WAIT;

    state_t                state, state_n;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  accept;
    logic                  load_rsp;
    logic                  misalign;
    logic [DATA_W-1:0]     rd_data;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [ADDR_W-1:0]     rsp_addr_q;
    logic                  unused_ld_bits;

    assign bus.req_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Zero wait states means the array is read on the accepting edge, before addr_q is loaded.
    assign sel_addr = (WAIT_CYCLES == 0) ? bus.req_addr : addr_q;
    assign load_rsp = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == '0);

`ifdef MISALIGN_TRAP_EN
    assign misalign = sel_addr[0];
`else
    assign misalign = 1'b0;
`endif

    assign unused_ld_bits = ^{ld_addr[ADDR_W-1:IDX_W+1], ld_addr[0]};

    imem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .re    (load_rsp && !misalign),
        .raddr (sel_addr[IDX_W:1]),
        .rdata (rd_data),
        .we    (ld_en),
        .waddr (ld_addr[IDX_W:1]),
        .wdata (ld_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = ACCEPT_ST;
            WAIT:    if (cnt == '0) state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = accept ? ACCEPT_ST : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (accept)
                cnt <= WAIT_LOAD;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) addr_q <= bus.req_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_n == RESP);
            if (load_rsp) begin
                rsp_addr_q <= sel_addr;
                rsp_err_q  <= misalign;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_err_q ? DATA_W'(NOP_WORD) : rd_data;
endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: one instance with one wait state, one with none, checked against a transaction model.
module tb_inst_mem_responder;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              ld_en   = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;

    logic              rv [2];
    logic [ADDR_W-1:0] ra [2];
    logic              rr [2];

    logic              o_rdy  [2];
    logic              o_vld  [2];
    logic              o_err  [2];
    logic [DATA_W-1:0] o_data [2];
    logic [ADDR_W-1:0] o_addr [2];

    inst_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc0 ();
    inst_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc1 ();

    assign ifc0.req_valid = rv[0];
    assign ifc0.req_addr  = ra[0];
    assign ifc0.rsp_ready = rr[0];
    assign ifc1.req_valid = rv[1];
    assign ifc1.req_addr  = ra[1];
    assign ifc1.rsp_ready = rr[1];

    assign o_rdy[0]  = ifc0.req_ready;
    assign o_vld[0]  = ifc0.rsp_valid;
    assign o_err[0]  = ifc0.rsp_err;
    assign o_data[0] = ifc0.rsp_data;
    assign o_addr[0] = ifc0.rsp_addr;
    assign o_rdy[1]  = ifc1.req_ready;
    assign o_vld[1]  = ifc1.rsp_valid;
    assign o_err[1]  = ifc1.rsp_err;
    assign o_data[1] = ifc1.rsp_data;
    assign o_addr[1] = ifc1.rsp_addr;

    inst_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );
    inst_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one fetch in flight per responder, valid WAIT+1 edges after accept.
    int                wc   [2] = '{1, 0};
    bit                busy [2] = '{1'b0, 1'b0};
    bit                mv   [2] = '{1'b0, 1'b0};
    int                left [2];
    logic [ADDR_W-1:0] cap  [2];
    logic [DATA_W-1:0] ed   [2];
    logic [ADDR_W-1:0] ea   [2];
    logic              ee   [2];
    logic [DATA_W-1:0] mem_m [DEPTH];

    function automatic void do_read(input int i);
        mv[i] = 1'b1;
        ea[i] = cap[i];
        if (TRAP && cap[i][0]) begin
            ed[i] = 16'h0000;
            ee[i] = 1'b1;
        end else begin
            ed[i] = mem_m[int'(cap[i] >> 1) % DEPTH];
            ee[i] = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy[i] = 1'b0;
                mv[i]   = 1'b0;
            end else begin
                bit rdy;
                rdy = !busy[i] || (mv[i] && rr[i]);
                if (mv[i] && rr[i]) begin
                    busy[i] = 1'b0;
                    mv[i]   = 1'b0;
                end
                if (busy[i] && !mv[i]) begin
                    left[i]--;
                    if (left[i] == 0) do_read(i);
                end else if (!busy[i] && rv[i] && rdy) begin
                    busy[i] = 1'b1;
                    cap[i]  = ra[i];
                    left[i] = wc[i];
                    if (wc[i] == 0) do_read(i);
                end
            end
        end
        if (ld_en) mem_m[int'(ld_addr >> 1) % DEPTH] = ld_data;
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("req_ready[%0d]", i), 32'(o_rdy[i]), 32'(!busy[i] || (mv[i] && rr[i])));
                chk($sformatf("rsp_valid[%0d]", i), 32'(o_vld[i]), 32'(mv[i]));
                if (mv[i]) begin
                    chk($sformatf("rsp_data[%0d]", i), 32'(o_data[i]), 32'(ed[i]));
                    chk($sformatf("rsp_addr[%0d]", i), 32'(o_addr[i]), 32'(ea[i]));
                    chk($sformatf("rsp_err[%0d]", i),  32'(o_err[i]),  32'(ee[i]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
    endtask

    task automatic fetch0(input string name, input logic [15:0] a, input logic [15:0] d, input logic e);
        step();
        rv[0] = 1'b1;
        ra[0] = a;
        step();
        rv[0] = 1'b0;
        step();
        @(negedge clk);
        chk({name, "_vld"},  32'(o_vld[0]),  32'd1);
        chk({name, "_data"}, 32'(o_data[0]), 32'(d));
        chk({name, "_addr"}, 32'(o_addr[0]), 32'(a));
        chk({name, "_err"},  32'(o_err[0]),  32'(e));
    endtask

    initial begin
        logic [15:0] t3_exp [4];
        t3_exp = '{16'h1234, 16'hABCD, 16'h5555, 16'h6666};
        rv = '{1'b0, 1'b0};
        ra = '{16'h0, 16'h0};
        rr = '{1'b1, 1'b1};
        step();
        step();
        @(negedge clk);
        chk("rst_vld",  32'(o_vld[0]),  32'd0);
        chk("rst_data", 32'(o_data[0]), 32'd0);
        chk("rst_addr", 32'(o_addr[0]), 32'd0);
        chk("rst_err",  32'(o_err[0]),  32'd0);
        chk("rst_rdy",  32'(o_rdy[0]),  32'd1);
        step();
        rst = 1'b0;

        load(16'h0000, 16'h1234);
        load(16'h0002, 16'hABCD);
        load(16'h0004, 16'h5555);
        load(16'h0006, 16'h6666);
        ld_en = 1'b0;

        // One wait state: valid two edges after the request is presented, later addr changes ignored.
        rr[0] = 1'b0;
        rv[0] = 1'b1;
        ra[0] = 16'h0002;
        step();
        rv[0] = 1'b0;
        ra[0] = 16'hFFFF;
        @(negedge clk);
        chk("t1_wait_vld", 32'(o_vld[0]), 32'd0);
        step();
        @(negedge clk);
        chk("t1_vld",  32'(o_vld[0]),  32'd1);
        chk("t1_data", 32'(o_data[0]), 32'hABCD);
        chk("t1_addr", 32'(o_addr[0]), 32'h0002);

        // Stalled response holds; release with a new request in the same cycle.
        repeat (3) begin
            step();
            @(negedge clk);
            chk("t2_hold_data", 32'(o_data[0]), 32'hABCD);
            chk("t2_hold_rdy",  32'(o_rdy[0]),  32'd0);
        end
        step();
        rr[0] = 1'b1;
        rv[0] = 1'b1;
        ra[0] = 16'h0000;
        @(negedge clk);
        chk("t2_b2b_rdy", 32'(o_rdy[0]), 32'd1);
        step();
        rv[0] = 1'b0;
        @(negedge clk);
        chk("t2_gap_vld", 32'(o_vld[0]), 32'd0);
        step();
        @(negedge clk);
        chk("t2_data", 32'(o_data[0]), 32'h1234);
        chk("t2_addr", 32'(o_addr[0]), 32'h0000);

        fetch0("t4_wrap", 16'h0802, 16'hABCD, 1'b0);
        if (TRAP) fetch0("t6_mis", 16'h0003, 16'h0000, 1'b1);
        else      fetch0("t6_mis", 16'h0003, 16'hABCD, 1'b0);

        // Reset while waiting drops the fetch.
        step();
        rv[0] = 1'b1;
        ra[0] = 16'h0000;
        step();
        rv[0] = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_vld", 32'(o_vld[0]), 32'd0);
        chk("t5_rdy", 32'(o_rdy[0]), 32'd1);
        repeat (3) step();
        @(negedge clk);
        chk("t5_no_rsp", 32'(o_vld[0]), 32'd0);

        // Zero wait states: one word per cycle in order.
        rv[1] = 1'b1;
        ra[1] = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            step();
            ra[1] = 16'(2 * (k + 1));
            if (k == 3) rv[1] = 1'b0;
            @(negedge clk);
            chk("t3_vld",  32'(o_vld[1]),  32'd1);
            chk("t3_data", 32'(o_data[1]), 32'(t3_exp[k]));
        end

        // Same-edge load and fetch of one word returns the old word.
        step();
        rv[1]   = 1'b1;
        ra[1]   = 16'h0002;
        ld_en   = 1'b1;
        ld_addr = 16'h0002;
        ld_data = 16'h7777;
        step();
        rv[1] = 1'b0;
        ld_en = 1'b0;
        @(negedge clk);
        chk("rbw_old", 32'(o_data[1]), 32'hABCD);
        step();
        rv[1] = 1'b1;
        ra[1] = 16'h0002;
        step();
        rv[1] = 1'b0;
        @(negedge clk);
        chk("rbw_new", 32'(o_data[1]), 32'h7777);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
